sblk_inst_sched: RTL and testbench
==================================

# sblk_inst_sched

Instruction scheduler for a row of `N_ROW` superblocks. It accepts a single host instruction stream and queues each instruction per row, or broadcasts it to all rows. It pulses each superblock's `inst_en` only when that superblock reports idle on `status_sblk`, and it supports barrier instructions that stall the stream until the whole row has drained. It sits between the top-level controller and the superblock row, driving that row's `inst_data`, `inst_en` and `status_sblk` bundle.

## Interface
- `N_ROW`, 6, number of superblocks in the row.
- `WID_INST`, 14, instruction width (TN+TM+TP+LN+LP fields, opaque here).
- `FIFO_DEPTH`, 4, per-row queue depth (power of two, ≥2).
- `BUSY_GUARD`, 2, cycles after issue during which `status_sblk` is ignored.
- `clk_l`  in  1  clock; single clock domain; reset is asynchronous and active-low.
- `rst_n`  in  1  asynchronous active-low reset.
- `host_inst_data`  in  `WID_INST`  instruction payload.
- `host_inst_row`  in  `$clog2(N_ROW)`  target row (ignored if bcast/barrier).
- `host_inst_bcast`  in  1  deliver to all rows.
- `host_inst_barrier`  in  1  barrier marker; carries no payload to rows.
- `host_inst_vld`  in  1  host entry valid.
- `host_inst_rdy`  out  1  scheduler can accept.
- `inst_data`  out  `WID_INST*N_ROW`  per-row instruction, row i at `[i*WID_INST +: WID_INST]`.
- `inst_en`  out  `N_ROW`  one-cycle issue strobe per row.
- `status_sblk`  in  `N_ROW`  1 = superblock busy.
- `sched_idle`  out  1  all FIFOs empty, all rows in IDLE, no barrier pending.
- `err_row`  out  1  sticky; an out-of-range row index was received.

## Operation
- Accept on `host_inst_vld && host_inst_rdy`.
- `host_inst_rdy` rules:
  - unicast: rdy = target FIFO not full;
  - bcast: rdy = all FIFOs not full;
  - barrier: rdy = `sched_idle`.
  - `rdy` does not depend combinationally on `vld`.
- Barrier accept consumes the entry and writes nothing to the rows.
- Unicast with `host_inst_row >= N_ROW`: the entry is accepted (rdy = 1), dropped, and `err_row` is set. Only reset clears `err_row`.
- Per-row FSM:
  - IDLE → ISSUE when the FIFO is non-empty;
  - ISSUE (1 cycle): pop the FIFO, drive `inst_en[i]` = 1 and latch `inst_data` → GUARD;
  - GUARD: `BUSY_GUARD` cycles → WAIT;
  - WAIT → IDLE when `status_sblk[i]` = 0.
- `inst_data` row slice holds its last issued value between issues.
- The host pushing and the row popping the same FIFO in one cycle is legal, including when the FIFO is full; count is unchanged.
- FIFO pointers wrap modulo `FIFO_DEPTH`. Full and empty are distinguished with an extra pointer bit.
- Rows run independently. Instruction order is preserved per row, not across rows.

## Timing
- Reset values: `inst_en` = 0, `inst_data` = 0, `host_inst_rdy` = 0 while `rst_n` = 0, `sched_idle` = 1, `err_row` = 0. All FSMs go to IDLE and all FIFOs to empty.
- Reset asserted mid-operation discards all queued entries and pending barriers immediately.
- All outputs are registered except `host_inst_rdy` and `sched_idle`, which are combinational from registered state.
- Latency: entry accepted in cycle T → `inst_en` high in T+1 at the earliest, when the row FIFO was empty and the row was IDLE.
- Minimum issue spacing per row: `BUSY_GUARD`+2 cycles.
- Barrier accepted in T → `host_inst_rdy` for the next entry is evaluated normally from T+1.

## Configuration
- `SBLK_INST_SCHED_PERF_EN` defined: adds output `perf_busy_cnt` (`32*N_ROW`). Each per-row counter increments each cycle the row is not IDLE, saturates at 2^32-1, and resets to 0.
- Undefined: the port and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package `sblk_pkg` holds:
  - enum `row_state_t` {IDLE, ISSUE, GUARD, WAIT};
  - struct `host_entry_t` {data, row, bcast, barrier};
  - localparam for the guard-counter width.
- Sub-module `sblk_inst_fifo`: one per row, synchronous FIFO with depth `FIFO_DEPTH`, providing simultaneous push/pop and full/empty flags.

## Test plan
- Unicast 0x0A5 to row 2, `status_sblk` = 0 → `inst_en` = 6'b000100 one cycle after accept, `inst_data[2]` = 0x0A5, others unchanged.
- Row 3 `status_sblk` held 1 for 20 cycles; push 5 entries to row 3 → 4 accepted, then `host_inst_rdy` = 0. After status drops, one issue per ≥4 cycles, in push order.
- Broadcast 0x1FF with row 0 FIFO full → rdy = 0 until row 0 pops; then all 6 `inst_en` pulse in the same cycle if all rows are IDLE.
- Barrier after unicasts to rows 1 and 4 (both busy 10 cycles) → barrier not accepted until both return to IDLE and FIFOs are empty; next entry accepted the cycle after.
- Row index 7 with `N_ROW` = 6 → accepted, no `inst_en`, `err_row` = 1 and sticky.
- Assert `rst_n` = 0 with 3 entries queued in row 0 → `inst_en` and `inst_data` = 0 immediately. After release, `sched_idle` = 1 and nothing is issued.

Source files
------------

// File: rtl/sblk_pkg.sv
// Shared types and constants for the superblock instruction scheduler:
// per-row FSM states, the host entry bundle and the guard-counter width.
package sblk_pkg;

    localparam int SBLK_N_ROW      = 6;
    localparam int SBLK_WID_INST   = 14;
    localparam int SBLK_FIFO_DEPTH = 4;
    localparam int SBLK_BUSY_GUARD = 2;
    localparam int SBLK_ROW_W      = $clog2(SBLK_N_ROW);
    localparam int SBLK_GUARD_W    = $clog2(SBLK_BUSY_GUARD + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GUARD = 2'd2,
        WAIT  = 2'd3
    } row_state_t;

    typedef struct packed {
        logic [SBLK_WID_INST-1:0] data;
        logic [SBLK_ROW_W-1:0]    row;
        logic                     bcast;
        logic                     barrier;
    } host_entry_t;

endpackage

// File: rtl/sblk_inst_fifo.sv
// Per-row synchronous instruction FIFO with simultaneous push/pop.
// Pointers carry one extra wrap bit to tell full from empty.
module sblk_inst_fifo #(
    parameter int WID   = 14,
    parameter int DEPTH = 4
) (
    input  logic           clk_l,
    input  logic           rst_n,
    input  logic           push,
    input  logic [WID-1:0] wdata,
    input  logic           pop,
    output logic [WID-1:0] rdata,
    output logic           full,
    output logic           empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0] wr_ptr_r;
    logic [PTR_W:0] rd_ptr_r;
    logic [WID-1:0] mem_r [DEPTH];
    logic           wr_s;
    logic           rd_s;

    assign empty = (wr_ptr_r == rd_ptr_r);
    assign full  = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                   (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
    assign rd_s  = pop & ~empty;
    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign wr_s  = push & (~full | rd_s);
    assign rdata = mem_r[rd_ptr_r[PTR_W-1:0]];

    // Storage and pointer update.
    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (wr_s) begin
                mem_r[wr_ptr_r[PTR_W-1:0]] <= wdata;
                wr_ptr_r <= wr_ptr_r + (PTR_W+1)'(1);
            end
            if (rd_s) begin
                rd_ptr_r <= rd_ptr_r + (PTR_W+1)'(1);
            end
        end
    end

endmodule

// File: rtl/sblk_inst_sched.sv
// Instruction scheduler for one superblock row: per-row queues, issue FSMs and barriers.
// Optional SBLK_INST_SCHED_PERF_EN adds per-row saturating busy-cycle counters.
module sblk_inst_sched
    import sblk_pkg::*;
#(
    parameter int N_ROW      = SBLK_N_ROW,
    parameter int WID_INST   = SBLK_WID_INST,
    parameter int FIFO_DEPTH = SBLK_FIFO_DEPTH,
    parameter int BUSY_GUARD = SBLK_BUSY_GUARD
) (
    input  logic                      clk_l,
    input  logic                      rst_n,
    input  logic [WID_INST-1:0]       host_inst_data,
    input  logic [$clog2(N_ROW)-1:0]  host_inst_row,
    input  logic                      host_inst_bcast,
    input  logic                      host_inst_barrier,
    input  logic                      host_inst_vld,
    output logic                      host_inst_rdy,
    output logic [WID_INST*N_ROW-1:0] inst_data,
    output logic [N_ROW-1:0]          inst_en,
    input  logic [N_ROW-1:0]          status_sblk,
    output logic                      sched_idle,
`ifdef SBLK_INST_SCHED_PERF_EN
    output logic [32*N_ROW-1:0]       perf_busy_cnt,
`endif
    output logic                      err_row
);

    host_entry_t               entry_s;
    logic                      row_ok_s;
    logic                      rdy_s;
    logic                      idle_s;
    logic                      accept_s;
    logic [N_ROW-1:0]          tgt_s;
    logic [N_ROW-1:0]          full_s;
    logic [N_ROW-1:0]          empty_s;
    logic [N_ROW-1:0]          push_s;
    logic [N_ROW-1:0]          pop_s;
    logic [N_ROW-1:0]          ready_s;
    logic [N_ROW-1:0]          go_s;
    logic [N_ROW-1:0]          row_idle_s;
    logic [WID_INST-1:0]       head_s       [N_ROW];
    logic [WID_INST-1:0]       issue_data_s [N_ROW];
    row_state_t                state_r      [N_ROW];
    row_state_t                state_nxt_s  [N_ROW];
    logic [SBLK_GUARD_W-1:0]   gcnt_r       [N_ROW];
    logic [SBLK_GUARD_W-1:0]   gcnt_nxt_s   [N_ROW];
    logic [N_ROW-1:0]          inst_en_r;
    logic [WID_INST*N_ROW-1:0] inst_data_r;
    logic                      err_row_r;

    assign entry_s  = '{data: host_inst_data, row: host_inst_row,
                        bcast: host_inst_bcast, barrier: host_inst_barrier};
    assign row_ok_s = (int'(entry_s.row) < N_ROW);
    assign accept_s = host_inst_vld & rdy_s;

    // Rows addressed by the offered entry; barriers and bad indices address none.
    always_comb begin
        tgt_s = '0;
        if (entry_s.barrier) begin
            tgt_s = '0;
        end else if (entry_s.bcast) begin
            tgt_s = '1;
        end else if (row_ok_s) begin
            tgt_s[entry_s.row] = 1'b1;
        end else begin
            tgt_s = '0;
        end
    end

    // Host ready from registered queue/FSM state only, held low during reset.
    always_comb begin
        rdy_s = 1'b0;
        if (!rst_n) begin
            rdy_s = 1'b0;
        end else if (entry_s.barrier) begin
            rdy_s = idle_s;
        end else if (entry_s.bcast) begin
            rdy_s = ~|full_s;
        end else if (row_ok_s) begin
            rdy_s = ~full_s[entry_s.row];
        end else begin
            rdy_s = 1'b1;
        end
    end

    assign host_inst_rdy = rdy_s;
    assign idle_s        = (&empty_s) & (&row_idle_s);
    assign sched_idle    = idle_s;

    // Issue decision; an entry arriving at an empty, ready row bypasses its FIFO.
    always_comb begin
        for (int i = 0; i < N_ROW; i++) begin
            row_idle_s[i]   = (state_r[i] == IDLE);
            ready_s[i]      = row_idle_s[i] | ((state_r[i] == WAIT) & ~status_sblk[i]);
            go_s[i]         = ready_s[i] & (~empty_s[i] | (tgt_s[i] & accept_s));
            pop_s[i]        = ready_s[i] & ~empty_s[i];
            push_s[i]       = tgt_s[i] & accept_s & ~(ready_s[i] & empty_s[i]);
            issue_data_s[i] = empty_s[i] ? entry_s.data : head_s[i];
        end
    end

    for (genvar gi = 0; gi < N_ROW; gi++) begin : g_row
        sblk_inst_fifo #(
            .WID   (WID_INST),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk_l (clk_l),
            .rst_n (rst_n),
            .push  (push_s[gi]),
            .wdata (entry_s.data),
            .pop   (pop_s[gi]),
            .rdata (head_s[gi]),
            .full  (full_s[gi]),
            .empty (empty_s[gi])
        );
    end

    // Per-row FSM next state; WAIT may chain straight into ISSUE when work is queued.
    always_comb begin
        for (int i = 0; i < N_ROW; i++) begin
            state_nxt_s[i] = state_r[i];
            gcnt_nxt_s[i]  = gcnt_r[i];
            case (state_r[i])
                IDLE: begin
                    if (go_s[i]) begin
                        state_nxt_s[i] = ISSUE;
                    end else begin
                        state_nxt_s[i] = IDLE;
                    end
                end
                ISSUE: begin
                    state_nxt_s[i] = GUARD;
                    gcnt_nxt_s[i]  = SBLK_GUARD_W'(1);
                end
                GUARD: begin
                    if (gcnt_r[i] >= SBLK_GUARD_W'(BUSY_GUARD)) begin
                        state_nxt_s[i] = WAIT;
                    end else begin
                        gcnt_nxt_s[i] = gcnt_r[i] + SBLK_GUARD_W'(1);
                    end
                end
                WAIT: begin
                    if (go_s[i]) begin
                        state_nxt_s[i] = ISSUE;
                    end else if (!status_sblk[i]) begin
                        state_nxt_s[i] = IDLE;
                    end else begin
                        state_nxt_s[i] = WAIT;
                    end
                end
                default: begin
                    state_nxt_s[i] = IDLE;
                    gcnt_nxt_s[i]  = '0;
                end
            endcase
        end
    end

    // FSM state and guard counters.
    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ROW; i++) begin
                state_r[i] <= IDLE;
                gcnt_r[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < N_ROW; i++) begin
                state_r[i] <= state_nxt_s[i];
                gcnt_r[i]  <= gcnt_nxt_s[i];
            end
        end
    end

    // Registered row outputs and the sticky bad-row flag.
    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            inst_en_r   <= '0;
            inst_data_r <= '0;
            err_row_r   <= 1'b0;
        end else begin
            inst_en_r <= go_s;
            for (int i = 0; i < N_ROW; i++) begin
                if (go_s[i]) begin
                    inst_data_r[i*WID_INST +: WID_INST] <= issue_data_s[i];
                end
            end
            if (accept_s && !entry_s.barrier && !entry_s.bcast && !row_ok_s) begin
                err_row_r <= 1'b1;
            end
        end
    end

    assign inst_en   = inst_en_r;
    assign inst_data = inst_data_r;
    assign err_row   = err_row_r;

`ifdef SBLK_INST_SCHED_PERF_EN
    logic [31:0] perf_cnt_r [N_ROW];

    // Busy-cycle counters, saturating at all-ones.
    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ROW; i++) begin
                perf_cnt_r[i] <= 32'd0;
            end
        end else begin
            for (int i = 0; i < N_ROW; i++) begin
                if ((state_r[i] != IDLE) && (perf_cnt_r[i] != 32'hFFFF_FFFF)) begin
                    perf_cnt_r[i] <= perf_cnt_r[i] + 32'd1;
                end
            end
        end
    end

    // Flatten counters onto the output bus.
    always_comb begin
        perf_busy_cnt = '0;
        for (int i = 0; i < N_ROW; i++) begin
            perf_busy_cnt[i*32 +: 32] = perf_cnt_r[i];
        end
    end
`endif

endmodule

// File: tb/tb_sblk_inst_sched.sv
// Self-checking bench for sblk_inst_sched: directed scenarios plus random traffic,
// every cycle compared against a queue-based reference model.
module tb_sblk_inst_sched;

    localparam int N_ROW = 6;
    localparam int W     = 14;
    localparam int D     = 4;
    localparam int BG    = 2;

    logic                  clk_l = 1'b0;
    logic                  rst_n;
    logic [W-1:0]          host_inst_data;
    logic [2:0]            host_inst_row;
    logic                  host_inst_bcast;
    logic                  host_inst_barrier;
    logic                  host_inst_vld;
    logic                  host_inst_rdy;
    logic [W*N_ROW-1:0]    inst_data;
    logic [N_ROW-1:0]      inst_en;
    logic [N_ROW-1:0]      status_sblk;
    logic                  sched_idle;
    logic                  err_row;

    sblk_inst_sched dut (
        .clk_l             (clk_l),
        .rst_n             (rst_n),
        .host_inst_data    (host_inst_data),
        .host_inst_row     (host_inst_row),
        .host_inst_bcast   (host_inst_bcast),
        .host_inst_barrier (host_inst_barrier),
        .host_inst_vld     (host_inst_vld),
        .host_inst_rdy     (host_inst_rdy),
        .inst_data         (inst_data),
        .inst_en           (inst_en),
        .status_sblk       (status_sblk),
        .sched_idle        (sched_idle),
        .err_row           (err_row)
    );

    always #5 clk_l = ~clk_l;

    int checks = 0;
    int errors = 0;

    // Reference model: pending entries per row, issue strobes, busy rows.
    logic [W-1:0]     q [N_ROW][$];
    logic [N_ROW-1:0] m_en;
    logic [W-1:0]     m_data [N_ROW];
    bit               m_busy [N_ROW];
    int               m_wfrom [N_ROW];
    bit               m_err;
    int               cyc;
    logic [N_ROW-1:0] status_v;
    bit               last_acc;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < N_ROW; r++) begin
            q[r].delete();
            m_data[r]  = '0;
            m_busy[r]  = 1'b0;
            m_wfrom[r] = 0;
        end
        m_en  = '0;
        m_err = 1'b0;
        cyc   = 0;
    endtask

    function automatic bit m_idle();
        for (int r = 0; r < N_ROW; r++) begin
            if (q[r].size() != 0 || m_busy[r]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic bit m_rdy(input logic [2:0] row, input bit bc, input bit br);
        if (br) return m_idle();
        if (bc) begin
            for (int r = 0; r < N_ROW; r++) begin
                if (q[r].size() >= D) return 1'b0;
            end
            return 1'b1;
        end
        if (int'(row) < N_ROW) return (q[row].size() < D);
        return 1'b1;
    endfunction

    function automatic logic [W*N_ROW-1:0] m_data_flat();
        logic [W*N_ROW-1:0] v;
        for (int r = 0; r < N_ROW; r++) v[r*W +: W] = m_data[r];
        return v;
    endfunction

    // One clock cycle: drive, compare at the falling edge, advance the model.
    task automatic tick(input bit vld, input logic [W-1:0] d, input logic [2:0] row,
                        input bit bc, input bit br);
        bit rdyx;
        bit acc;
        bit ready;
        host_inst_vld     = vld;
        host_inst_data    = d;
        host_inst_row     = row;
        host_inst_bcast   = bc;
        host_inst_barrier = br;
        status_sblk       = status_v;
        @(negedge clk_l);
        rdyx = m_rdy(row, bc, br);
        chk("inst_en", inst_en, m_en);
        chk("inst_data", inst_data, m_data_flat());
        chk("host_inst_rdy", host_inst_rdy, rdyx);
        chk("sched_idle", sched_idle, m_idle());
        chk("err_row", err_row, m_err);
        acc      = vld && rdyx;
        last_acc = acc;
        if (acc && !br) begin
            if (bc) begin
                for (int r = 0; r < N_ROW; r++) q[r].push_back(d);
            end else if (int'(row) < N_ROW) begin
                q[row].push_back(d);
            end else begin
                m_err = 1'b1;
            end
        end
        for (int r = 0; r < N_ROW; r++) begin
            ready = !m_busy[r] || (cyc >= m_wfrom[r] && !status_v[r]);
            if (ready && q[r].size() > 0) begin
                m_data[r]  = q[r].pop_front();
                m_en[r]    = 1'b1;
                m_busy[r]  = 1'b1;
                m_wfrom[r] = cyc + 1 + BG + 1;
            end else begin
                m_en[r] = 1'b0;
                if (ready) m_busy[r] = 1'b0;
            end
        end
        cyc++;
        @(posedge clk_l);
        #1;
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, '0, 3'd0, 1'b0, 1'b0);
    endtask

    // Hold an entry valid until accepted, within a cycle budget.
    task automatic send(input logic [W-1:0] d, input logic [2:0] row, input bit bc,
                        input bit br, input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            tick(1'b1, d, row, bc, br);
            done = last_acc;
        end
        chk("accept_within_budget", done, 1'b1);
        host_inst_vld = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_cnt;
        // Reset state, with an entry offered to prove rdy stays low.
        rst_n             = 1'b0;
        status_v          = '0;
        status_sblk       = '0;
        host_inst_vld     = 1'b1;
        host_inst_data    = 14'h0A5;
        host_inst_row     = 3'd2;
        host_inst_bcast   = 1'b0;
        host_inst_barrier = 1'b0;
        model_reset();
        #3;
        chk("rst_inst_en", inst_en, 6'h00);
        chk("rst_inst_data", inst_data, '0);
        chk("rst_rdy", host_inst_rdy, 1'b0);
        chk("rst_sched_idle", sched_idle, 1'b1);
        chk("rst_err_row", err_row, 1'b0);
        host_inst_vld = 1'b0;
        repeat (2) @(posedge clk_l);
        @(negedge clk_l);
        rst_n = 1'b1;
        @(posedge clk_l);
        #1;

        // Unicast to an idle row issues one cycle after accept.
        idle_n(2);
        send(14'h0A5, 3'd2, 1'b0, 1'b0, 1);
        chk("uni_en_row2", inst_en, 6'b000100);
        chk("uni_data_row2", inst_data[2*W +: W], 14'h0A5);
        chk("uni_data_row0", inst_data[0 +: W], 14'h0000);
        idle_n(6);

        // Row 3 held busy: after one issue its FIFO takes exactly four more.
        status_v[3] = 1'b1;
        send(14'h300, 3'd3, 1'b0, 1'b0, 1);
        idle_n(4);
        acc_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 14'(14'h301 + i), 3'd3, 1'b0, 1'b0);
            if (last_acc) acc_cnt++;
        end
        chk("row3_accepted", acc_cnt, 4);
        chk("row3_rdy_full", host_inst_rdy, 1'b0);
        idle_n(12);
        status_v[3] = 1'b0;
        idle_n(24);

        // Broadcast blocked by a full row 0 until row 0 pops.
        status_v[0] = 1'b1;
        send(14'h010, 3'd0, 1'b0, 1'b0, 1);
        for (int i = 0; i < 4; i++) send(14'(14'h011 + i), 3'd0, 1'b0, 1'b0, 1);
        for (int i = 0; i < 6; i++) tick(1'b1, 14'h1FF, 3'd0, 1'b1, 1'b0);
        status_v[0] = 1'b0;
        send(14'h1FF, 3'd0, 1'b1, 1'b0, 20);
        idle_n(30);
        send(14'h155, 3'd1, 1'b1, 1'b0, 1);
        chk("bcast_all_en", inst_en, 6'h3F);
        chk("bcast_data_row5", inst_data[5*W +: W], 14'h155);
        idle_n(8);

        // Barrier waits for rows 1 and 4 to drain; next entry goes straight after.
        status_v[1] = 1'b1;
        status_v[4] = 1'b1;
        send(14'h111, 3'd1, 1'b0, 1'b0, 1);
        send(14'h144, 3'd4, 1'b0, 1'b0, 1);
        for (int i = 0; i < 10; i++) tick(1'b1, '0, 3'd0, 1'b0, 1'b1);
        status_v[1] = 1'b0;
        status_v[4] = 1'b0;
        send(14'h000, 3'd0, 1'b0, 1'b1, 10);
        send(14'h255, 3'd5, 1'b0, 1'b0, 1);
        idle_n(6);

        // Out-of-range row: accepted, dropped, sticky error.
        send(14'h077, 3'd7, 1'b0, 1'b0, 1);
        chk("err_row_set", err_row, 1'b1);
        chk("err_row_no_en", inst_en, 6'h00);
        idle_n(5);
        chk("err_row_sticky", err_row, 1'b1);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            for (int r = 0; r < N_ROW; r++) begin
                if ($urandom_range(0, 5) == 0) status_v[r] = ~status_v[r];
            end
            tick($urandom_range(0, 3) != 0, 14'($urandom), 3'($urandom_range(0, 7)),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
        end
        status_v = '0;
        idle_n(40);

        // Reset mid-operation with entries queued in row 0.
        status_v[0] = 1'b1;
        for (int i = 0; i < 4; i++) send(14'(14'h3A0 + i), 3'd0, 1'b0, 1'b0, 1);
        idle_n(2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_inst_en", inst_en, 6'h00);
        chk("midrst_inst_data", inst_data, '0);
        chk("midrst_rdy", host_inst_rdy, 1'b0);
        chk("midrst_sched_idle", sched_idle, 1'b1);
        chk("midrst_err_row", err_row, 1'b0);
        @(negedge clk_l);
        rst_n    = 1'b1;
        status_v = '0;
        @(posedge clk_l);
        #1;
        model_reset();
        idle_n(10);
        chk("post_rst_idle", sched_idle, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
